// File: rtl/serial_addsub_pkg.sv
// -----------------------------------------------------------------------------
// serial_addsub_pkg
// Shared types and constants for the bit-serial add/subtract sequencer.
//   state_t        : controller FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH  : default operand width
//   cnt_width()    : bit-counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage : serial_addsub_pkg

// File: rtl/addsub_bit.sv
// -----------------------------------------------------------------------------
// addsub_bit
// Purely combinational one-bit add/subtract cell. Subtraction is formed by
// inverting b; the caller supplies the initial carry of 1.
//   a, b  : operand bits
//   cin   : carry in
//   sub   : 0 = add, 1 = subtract
//   s     : sum bit
//   co    : carry out
// -----------------------------------------------------------------------------
module addsub_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   input  logic sub,
   output logic s,
   output logic co
);

   logic bi;

   assign bi = b ^ sub;
   assign s  = a ^ bi ^ cin;
   assign co = (a & bi) | (a & cin) | (bi & cin);

endmodule : addsub_bit

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
// Bit-serial add/subtract sequencer. A single addsub_bit cell is time-shared
// over all WIDTH bit positions, LSB first, one bit per clock, with the carry
// held in a flip-flop between bits.
//
// Parameters
//   WIDTH   : operand/result width, 2..32
// Ports
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   start   : request, sampled only in IDLE
//   op_sub  : 0 = a+b, 1 = a-b (sampled with start)
//   a, b    : operands (sampled with start)
//   busy    : high while the bits are being processed
//   done    : one-cycle completion pulse
//   result  : sum/difference, valid at and after done
//   cout    : final carry out (subtract: 1 = no borrow)
//   ovf     : signed overflow
//
// Build option
//   SERIAL_ADDSUB_OVF_EN : when defined, ovf is computed from the carries
//                          into and out of the MSB and registered; otherwise
//                          ovf is tied to 0 and that logic is omitted.
// -----------------------------------------------------------------------------
module serial_addsub_ctrl
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             op_sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             sub_q;
   logic             carry;

   logic             cell_s;
   logic             cell_co;

   addsub_bit u_cell (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (carry),
      .sub (sub_q),
      .s   (cell_s),
      .co  (cell_co)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         a_sh   <= '0;
         b_sh   <= '0;
         sub_q  <= 1'b0;
         carry  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         cout   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  a_sh  <= a;
                  b_sh  <= b;
                  sub_q <= op_sub;
                  // Initial carry of 1 completes the two's complement of b.
                  carry <= op_sub;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end

            RUN: begin
               // Sum bits enter at the MSB so that after WIDTH shifts the
               // first (LSB) bit has reached position 0.
               result <= {cell_s, result[WIDTH-1:1]};
               carry  <= cell_co;
               a_sh   <= a_sh >> 1;
               b_sh   <= b_sh >> 1;
               cnt    <= cnt + CNT_W'(1);
               if (cnt == LAST_BIT) begin
                  cout  <= cell_co;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef SERIAL_ADDSUB_OVF_EN
   logic ovf_q;

   // On the last bit, carry holds the carry into the MSB and cell_co the
   // carry out of it; they differ exactly on signed overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (state == RUN && cnt == LAST_BIT) begin
         ovf_q <= carry ^ cell_co;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_ctrl
// Self-checking bench for serial_addsub_ctrl (WIDTH=8). Expected results are
// computed by a word-level reference model when a request is accepted, queued,
// and compared when done is seen.
// -----------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

   localparam int W = 8;

   typedef struct packed {
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         start;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         cout;
   logic         ovf;

   exp_t sb[$];
   int   n_tests;
   int   n_fail;

   serial_addsub_ctrl #(.WIDTH(W)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op_sub (op_sub),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .cout   (cout),
      .ovf    (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_tests++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic sub);
      exp_t         e;
      logic [W-1:0] yi;
      logic [W:0]   s;
      yi = sub ? ~y : y;
      s  = {1'b0, x} + {1'b0, yi} + {{W{1'b0}}, sub};
      e.res = s[W-1:0];
      e.co  = s[W];
`ifdef SERIAL_ADDSUB_OVF_EN
      e.ov  = (x[W-1] == yi[W-1]) && (s[W-1] != x[W-1]);
`else
      e.ov  = 1'b0;
`endif
      return e;
   endfunction

   // Scoreboard consumer: compare on every done pulse.
   always @(negedge clk) begin
      exp_t e;
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("result", {24'd0, result}, {24'd0, e.res});
            chk("cout",   {31'd0, cout},   {31'd0, e.co});
            chk("ovf",    {31'd0, ovf},    {31'd0, e.ov});
         end
      end
   end

   // One operation; optionally pulses a competing start mid-run.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                        input logic ts, input logic inject);
      int   lat;
      exp_t e;
      @(negedge clk);
      a = ta; b = tbv; op_sub = ts; start = 1'b1;
      @(posedge clk);
      e = model(ta, tbv, ts);
      sb.push_back(e);
      @(negedge clk);
      start = 1'b0;
      chk("busy_after_accept", {31'd0, busy}, 32'd1);
      lat = 0;
      while (!done && lat < 40) begin
         @(posedge clk);
         lat++;
         #1;
         if (inject && lat == 2) begin
            a = ~ta; b = ~tbv; op_sub = ~ts; start = 1'b1;
         end else if (inject && lat == 3) begin
            start = 1'b0;
         end
      end
      chk("latency", lat, W);
      if (!done && sb.size() > 0) void'(sb.pop_back());
      @(negedge clk);
      // Result must hold after done, and an ignored start must not relaunch.
      @(negedge clk);
      chk("result_held", {24'd0, result}, {24'd0, e.res});
      chk("idle_after_done", {31'd0, busy}, 32'd0);
   endtask

   task automatic reset_mid_run();
      @(negedge clk);
      a = 8'hFF; b = 8'h00; op_sub = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("pre_rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("rst_busy",   {31'd0, busy},   32'd0);
      chk("rst_done",   {31'd0, done},   32'd0);
      chk("rst_result", {24'd0, result}, 32'd0);
      chk("rst_cout",   {31'd0, cout},   32'd0);
      chk("rst_ovf",    {31'd0, ovf},    32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst = 1'b1; start = 1'b0; op_sub = 1'b0; a = '0; b = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy",   {31'd0, busy},   32'd0);
      chk("reset_done",   {31'd0, done},   32'd0);
      chk("reset_result", {24'd0, result}, 32'd0);
      chk("reset_cout",   {31'd0, cout},   32'd0);
      chk("reset_ovf",    {31'd0, ovf},    32'd0);
      rst = 1'b0;

      do_op(8'h35, 8'h4A, 1'b0, 1'b0);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      do_op(8'h10, 8'h20, 1'b1, 1'b0);
      do_op(8'h7F, 8'h01, 1'b0, 1'b0);
      do_op(8'h80, 8'h01, 1'b1, 1'b0);
      do_op(8'hC3, 8'h5A, 1'b0, 1'b1);
      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      reset_mid_run();
      do_op(8'h12, 8'h34, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         do_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)),
               1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_serial_addsub_ctrl
